// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C master between NREQ requesters.
// Optional WAIT watchdog is compiled in with `define I2C_ARB_TIMEOUT_EN.
module i2c_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_rw,
  input  logic [7*NREQ-1:0]   req_addr,
  input  logic [8*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     done,
  output logic [7:0]          rdata,
  output logic                err,
  output logic                m_start,
  output logic                m_rw,
  output logic [6:0]          m_addr,
  output logic [7:0]          m_wdata,
  output logic                m_abort,
  input  logic                m_busy,
  input  logic                m_done,
  input  logic [7:0]          m_rdata,
  input  logic                m_nack
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_idx;
  logic            win_found;
  logic            take;
  logic            timeout_hit;

  // Watchdog: counts WAIT cycles; fires on the cycle the count reaches TIMEOUT_CYC.
`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst)                wait_cnt <= '0;
    else if (state == ISSUE) wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + 16'd1;
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == 16'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign timeout_hit    = 1'b0;
`endif

  // Winner is the first pending requester after the last one served, wrapping.
  always_comb begin
    int            j;
    logic [PW-1:0] jj;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    jj        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = PW'(j);
      if (!win_found && req[jj]) begin
        win_found = 1'b1;
        win_idx   = jj;
      end
    end
  end

  assign take = (state == IDLE) && win_found && !m_busy;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaulting every combinational output first keeps unlisted paths from inferring latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (m_done || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_start = (state == ISSUE);
    done    = (state == RESP) ? grant : '0;
    m_abort = timeout_hit && !m_done;
  end

  // Request fields are captured once at grant; the master sees only the latched copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant   <= '0;
      ptr     <= PTR_RST;
      m_rw    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            grant   <= NREQ'(1) << win_idx;
            ptr     <= win_idx;
            m_rw    <= req_rw[win_idx];
            m_addr  <= req_addr[7*win_idx +: 7];
            m_wdata <= req_wdata[8*win_idx +: 8];
          end
        end
        WAIT: begin
          if (m_done) begin
            rdata <= m_rdata;
            err   <= m_nack;
          end else if (timeout_hit) begin
            rdata <= 8'h00;
            err   <= 1'b1;
          end
        end
        RESP:    grant <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin reference model.
module tb_i2c_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 16;
  localparam int AW   = 7 * NREQ;
  localparam int WW   = 8 * NREQ;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req, req_rw, grant, done;
  logic [AW-1:0]   req_addr;
  logic [WW-1:0]   req_wdata;
  logic [7:0]      rdata, m_wdata, m_rdata;
  logic            err, m_start, m_rw, m_abort, m_busy, m_done, m_nack;
  logic [6:0]      m_addr;

  int total = 0;
  int bad   = 0;

  int              mptr;
  int              exp_w;
  logic [NREQ-1:0] exp_g;
  logic [6:0]      exp_addr;
  logic            exp_rw;
  logic [7:0]      exp_wd;

  i2c_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .done(done), .rdata(rdata), .err(err),
    .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_abort(m_abort), .m_busy(m_busy), .m_done(m_done), .m_rdata(m_rdata),
    .m_nack(m_nack)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first requester set after the previous owner, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; m_done = 1'b0; m_busy = 1'b0; m_nack = 1'b0;
    cyc();
    cyc();
    rst  = 1'b0;
    mptr = NREQ - 1;
  endtask

  // Called in an IDLE cycle with requests applied; next cycle must be ISSUE for the model winner.
  task automatic expect_grant();
    exp_w = pick(req, mptr);
    if (exp_w < 0) exp_w = 0;
    exp_g = '0;
    exp_g[exp_w] = 1'b1;
    exp_addr = req_addr[7*exp_w +: 7];
    exp_rw   = req_rw[exp_w];
    exp_wd   = req_wdata[8*exp_w +: 8];
    cyc();
    total++;
    if ({m_start, grant, m_addr, m_rw, m_wdata} !== {1'b1, exp_g, exp_addr, exp_rw, exp_wd}) begin
      bad++;
      $display("FAIL grant: start=%b grant=%b addr=%h rw=%b wdata=%h, want 1 %b %h %b %h",
               m_start, grant, m_addr, m_rw, m_wdata, exp_g, exp_addr, exp_rw, exp_wd);
    end
    mptr = exp_w;
  endtask

  // From ISSUE: master answers lat cycles after m_start; requester fields are scrambled meanwhile.
  task automatic serve(input int lat, input logic [7:0] rd, input logic nk, input bit drop);
    for (int c = 1; c <= lat; c++) begin
      cyc();
      total++;
      if ({m_start, grant, m_addr, m_rw, m_wdata, done, m_abort} !==
          {1'b0, exp_g, exp_addr, exp_rw, exp_wd, {NREQ{1'b0}}, 1'b0}) begin
        bad++;
        $display("FAIL wait_hold: start=%b grant=%b addr=%h rw=%b wdata=%h done=%b abort=%b, want grant=%b addr=%h",
                 m_start, grant, m_addr, m_rw, m_wdata, done, m_abort, exp_g, exp_addr);
      end
      req_addr  = AW'($urandom);
      req_wdata = WW'($urandom);
      req_rw    = NREQ'($urandom);
      if (c == lat) begin
        m_done = 1'b1; m_rdata = rd; m_nack = nk;
      end
    end
    cyc();
    m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'hEE;
    total++;
    if ({done, rdata, err} !== {exp_g, rd, nk}) begin
      bad++;
      $display("FAIL resp: done=%b rdata=%h err=%b, want %b %h %b", done, rdata, err, exp_g, rd, nk);
    end
    if (drop) req[exp_w] = 1'b0;
    cyc();
    total++;
    if ({done, grant, m_start} !== '0) begin
      bad++;
      $display("FAIL back_idle: done=%b grant=%b start=%b, want 0", done, grant, m_start);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({grant, done, rdata, err, m_start, m_rw, m_addr, m_wdata, m_abort} !== '0) begin
      bad++;
      $display("FAIL reset_state: grant=%b done=%b rdata=%h err=%b start=%b rw=%b addr=%h wdata=%h abort=%b, want 0",
               grant, done, rdata, err, m_start, m_rw, m_addr, m_wdata, m_abort);
    end
  endtask

  task automatic test_single_read();
    req_rw[0] = 1'b1;
    req_addr[6:0] = 7'h48;
    req = 4'b0001;
    expect_grant();
    total++;
    if ({m_addr, m_rw} !== {7'h48, 1'b1}) begin
      bad++;
      $display("FAIL single_fields: addr=%h rw=%b, want 48 1", m_addr, m_rw);
    end
    serve(10, 8'hA5, 1'b0, 1'b1);
  endtask

  task automatic test_nack();
    req_rw[2] = 1'b0;
    req_wdata[23:16] = 8'h3C;
    req = 4'b0100;
    expect_grant();
    total++;
    if ({grant, m_wdata, m_rw} !== {4'b0100, 8'h3C, 1'b0}) begin
      bad++;
      $display("FAIL nack_fields: grant=%b wdata=%h rw=%b, want 0100 3c 0", grant, m_wdata, m_rw);
    end
    serve(4, 8'h5A, 1'b1, 1'b1);
  endtask

  task automatic test_busy_latch();
    m_busy = 1'b1;
    req_addr[13:7] = 7'h21;
    req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if ({m_start, grant, done} !== '0) begin
        bad++;
        $display("FAIL busy_gate: start=%b grant=%b done=%b, want 0", m_start, grant, done);
      end
      m_done = (i == 1);
    end
    m_done = 1'b0;
    m_busy = 1'b0;
    expect_grant();
    total++;
    if (m_addr !== 7'h21) begin
      bad++;
      $display("FAIL busy_addr: addr=%h, want 21", m_addr);
    end
    serve(6, 8'h11, 1'b0, 1'b1);
  endtask

  task automatic test_round_robin();
    do_reset();
    req_addr  = AW'($urandom);
    req_wdata = WW'($urandom);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      expect_grant();
      total++;
      if (grant !== NREQ'(1 << (i % NREQ))) begin
        bad++;
        $display("FAIL rr_order: step=%0d grant=%b, want %b", i, grant, NREQ'(1 << (i % NREQ)));
      end
      serve(int'($urandom_range(1, 5)), 8'h80 | 8'($urandom), 1'b0, 1'b0);
    end
    req = '0;
  endtask

  task automatic test_reset_mid_wait();
    req = 4'b0010;
    expect_grant();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    total++;
    if ({grant, done, rdata, err, m_start, m_rw, m_addr, m_wdata, m_abort} !== '0) begin
      bad++;
      $display("FAIL mid_reset: grant=%b done=%b rdata=%h err=%b start=%b rw=%b addr=%h wdata=%h abort=%b, want 0",
               grant, done, rdata, err, m_start, m_rw, m_addr, m_wdata, m_abort);
    end
    rst  = 1'b0;
    mptr = NREQ - 1;
    req  = 4'b1001;
    expect_grant();
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL post_reset_first: grant=%b, want 0001", grant);
    end
    serve(3, 8'h42, 1'b0, 1'b1);
    expect_grant();
    total++;
    if (grant !== 4'b1000) begin
      bad++;
      $display("FAIL post_reset_second: grant=%b, want 1000", grant);
    end
    serve(2, 8'h24, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      req = req | NREQ'($urandom);
      if (req == '0) req[$urandom_range(NREQ - 1)] = 1'b1;
      if ($urandom_range(3) == 0) begin
        m_busy = 1'b1;
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          cyc();
          total++;
          if ({m_start, grant} !== '0) begin
            bad++;
            $display("FAIL rand_busy: start=%b grant=%b, want 0", m_start, grant);
          end
        end
        m_busy = 1'b0;
      end
      expect_grant();
      serve(int'($urandom_range(1, 8)), 8'($urandom), 1'($urandom), 1'b1);
    end
    req = '0;
    cyc();
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout();
    req = 4'b0001;
    expect_grant();
    for (int c = 1; c <= TO; c++) begin
      cyc();
      total++;
      if (m_abort !== (c == TO)) begin
        bad++;
        $display("FAIL timeout_abort: wait_cycle=%0d abort=%b, want %b", c, m_abort, (c == TO));
      end
    end
    req = '0;
    cyc();
    total++;
    if ({done, err, rdata} !== {4'b0001, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL timeout_resp: done=%b err=%b rdata=%h, want 0001 1 00", done, err, rdata);
    end
    cyc();
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    m_busy = 1'b0; m_done = 1'b0; m_rdata = '0; m_nack = 1'b0;
    mptr = NREQ - 1;
    test_reset();
    test_single_read();
    test_nack();
    test_busy_latch();
    test_round_robin();
    test_reset_mid_wait();
    test_random();
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
